auto_contrast_master: RTL and testbench

Measures per-frame pixel minimum and maximum on the incoming 16-bit video stream. At each frame end it programs the contrast_video register file over its Avalon-MM interface as an Avalon master: zoom denominator and numerator, input minimum, and enable. The block sits in parallel with contrast_video on the same video bus, so the stretch applied to frame N+1 tracks the statistics of frame N without CPU involvement. The contrast_video AV_CLK/AV_nRES are tied to this block's IN_CLK/nRESET in this integration.

---
 rtl/auto_contrast_master.sv | 234 +++++++++++++++++++++++
 tb/tb_auto_contrast_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_contrast_master.sv
// Per-frame min/max statistics with automatic programming of the contrast_video
// register file over Avalon-MM (zoom/max, min, enable) at every frame end.
module auto_contrast_master #(
    parameter int unsigned ZOOM_NUMERATOR = 255,
    parameter int unsigned MIN_SPAN       = 16,
    parameter int unsigned WAIT_TIMEOUT   = 255
) (
    input  logic        IN_CLK,
    input  logic        nRESET,
    input  logic        IN_LINE,
    input  logic        IN_FRAME,
    input  logic [15:0] IN_VIDEO_DATA,
    input  logic        ENABLE,
    output logic        AV_CS,
    output logic        AV_nWR,
    output logic        AV_nRD,
    output logic [2:0]  AV_ADDR,
    output logic [31:0] AV_WRITEDATA,
    input  logic        AV_WAITREQ,
    output logic        BUSY,
    output logic [15:0] FRAME_MIN,
    output logic [15:0] FRAME_MAX,
    output logic [7:0]  DROP_CNT,
    output logic        AV_ERR
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned SW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ZOOM = 3'd1,
        GAP1    = 3'd2,
        WR_MIN  = 3'd3,
        GAP2    = 3'd4,
        WR_ON   = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_stall, w_stall_nxt;
    logic            w_done, w_abort;

    logic            r_frame_d;
    logic [DW-1:0]   r_acc_min, r_acc_max;
    logic            r_has_pix;
    logic [DW-1:0]   r_sh_min, r_sh_max;
    logic            r_sh_en;
    logic            r_req;

    logic            r_cs, r_nwr, r_busy, r_err;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [DW-1:0]   r_fmin, r_fmax;
    logic [7:0]      r_drop;

    logic            w_cs_nxt, w_nwr_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic [31:0]     w_wdata_nxt;

    logic            w_frame_end, w_pix, w_pending;
    logic [DW:0]     w_sum, w_span;
    logic [DW-1:0]   w_cmin, w_cmax;

    assign w_frame_end = r_frame_d & ~IN_FRAME;
    assign w_pix       = IN_FRAME & IN_LINE;
    assign w_pending   = (r_state != IDLE) | r_req;

    // Span clamp on the finished accumulators, 17-bit to catch overflow past 65535
    always_comb begin
        w_sum  = {1'b0, r_acc_min} + (DW+1)'(MIN_SPAN);
        w_span = {1'b0, r_acc_max} - {1'b0, r_acc_min};
        w_cmin = r_acc_min;
        w_cmax = r_acc_max;
        if (w_sum > (DW+1)'(17'h0FFFF)) begin
            w_cmin = DW'((DW+1)'(17'h0FFFF) - (DW+1)'(MIN_SPAN));
            w_cmax = 16'hFFFF;
        end else if (w_span < (DW+1)'(MIN_SPAN)) begin
            w_cmax = w_sum[DW-1:0];
        end
    end

    // Statistics accumulation, shadow latch and drop accounting
    always_ff @(posedge IN_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_frame_d <= 1'b0;
            r_acc_min <= 16'hFFFF;
            r_acc_max <= 16'h0000;
            r_has_pix <= 1'b0;
            r_sh_min  <= 16'h0000;
            r_sh_max  <= 16'hFFFF;
            r_sh_en   <= 1'b0;
            r_req     <= 1'b0;
            r_drop    <= 8'd0;
        end else begin
            r_frame_d <= IN_FRAME;
            if (r_state == IDLE && r_req) begin
                r_req <= 1'b0;
            end
            if (w_frame_end) begin
                r_acc_min <= 16'hFFFF;
                r_acc_max <= 16'h0000;
                r_has_pix <= 1'b0;
                if (r_has_pix) begin
                    if (w_pending) begin
                        if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end else begin
                        r_sh_min <= w_cmin;
                        r_sh_max <= w_cmax;
                        r_sh_en  <= ENABLE;
                        r_req    <= 1'b1;
                    end
                end
            end else if (w_pix) begin
                r_has_pix <= 1'b1;
                if (IN_VIDEO_DATA < r_acc_min) begin
                    r_acc_min <= IN_VIDEO_DATA;
                end
                if (IN_VIDEO_DATA > r_acc_max) begin
                    r_acc_max <= IN_VIDEO_DATA;
                end
            end
        end
    end

    // Write-sequence next state and next registered bus outputs
    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_cs_nxt    = 1'b0;
        w_nwr_nxt   = 1'b1;
        w_addr_nxt  = AW'(0);
        w_wdata_nxt = 32'h0;

        case (r_state)
            IDLE: begin
                if (r_req) begin
                    w_state_nxt = r_sh_en ? WR_ZOOM : WR_ON;
                    w_stall_nxt = SW'(0);
                end
            end
            WR_ZOOM, WR_MIN, WR_ON: begin
                if (!AV_WAITREQ) begin
                    w_stall_nxt = SW'(0);
                    case (r_state)
                        WR_ZOOM: w_state_nxt = GAP1;
                        WR_MIN:  w_state_nxt = GAP2;
                        default: begin
                            w_state_nxt = IDLE;
                            w_done      = 1'b1;
                        end
                    endcase
                end else if (r_stall == SW'(WAIT_TIMEOUT - 1)) begin
                    w_state_nxt = IDLE;
                    w_stall_nxt = SW'(0);
                    w_abort     = 1'b1;
                end else begin
                    w_stall_nxt = r_stall + SW'(1);
                end
            end
            GAP1:    w_state_nxt = WR_MIN;
            GAP2:    w_state_nxt = WR_ON;
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            WR_ZOOM: begin
                w_cs_nxt    = 1'b1;
                w_nwr_nxt   = 1'b0;
                w_addr_nxt  = AW'(1);
                w_wdata_nxt = {16'(ZOOM_NUMERATOR), r_sh_max};
            end
            WR_MIN: begin
                w_cs_nxt    = 1'b1;
                w_nwr_nxt   = 1'b0;
                w_addr_nxt  = AW'(2);
                w_wdata_nxt = {16'h0, r_sh_min};
            end
            WR_ON: begin
                w_cs_nxt    = 1'b1;
                w_nwr_nxt   = 1'b0;
                w_addr_nxt  = AW'(0);
                w_wdata_nxt = {31'h0, r_sh_en};
            end
            default: ;
        endcase
    end

    always_ff @(posedge IN_CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= IDLE;
            r_stall <= SW'(0);
            r_cs    <= 1'b0;
            r_nwr   <= 1'b1;
            r_addr  <= AW'(0);
            r_wdata <= 32'h0;
            r_busy  <= 1'b0;
            r_fmin  <= 16'h0000;
            r_fmax  <= 16'hFFFF;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall_nxt;
            r_cs    <= w_cs_nxt;
            r_nwr   <= w_nwr_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_abort) begin
                r_err <= 1'b1;
            end
            if (w_done) begin
                r_fmin <= r_sh_min;
                r_fmax <= r_sh_max;
            end
        end
    end

    assign AV_CS        = r_cs;
    assign AV_nWR       = r_nwr;
    assign AV_nRD       = 1'b1;
    assign AV_ADDR      = r_addr;
    assign AV_WRITEDATA = r_wdata;
    assign BUSY         = r_busy;
    assign FRAME_MIN    = r_fmin;
    assign FRAME_MAX    = r_fmax;
    assign DROP_CNT     = r_drop;
    assign AV_ERR       = r_err;

endmodule

// File: tb/tb_auto_contrast_master.sv
// Directed bench for auto_contrast_master with a contrast_video style slave
// (WAITREQ idles 1, drops 0 on the third cycle of each access).
module tb_auto_contrast_master;

    logic        IN_CLK = 1'b0;
    logic        nRESET;
    logic        IN_LINE, IN_FRAME, ENABLE;
    logic [15:0] IN_VIDEO_DATA;
    logic        AV_CS, AV_nWR, AV_nRD;
    logic [2:0]  AV_ADDR;
    logic [31:0] AV_WRITEDATA;
    logic        AV_WAITREQ;
    logic        BUSY, AV_ERR;
    logic [15:0] FRAME_MIN, FRAME_MAX;
    logic [7:0]  DROP_CNT;

    int checks = 0;
    int errors = 0;

    logic       hold = 1'b0;
    logic [1:0] s_cnt = 2'd0;
    logic [2:0]  wq_a[$];
    logic [31:0] wq_d[$];

    auto_contrast_master dut (
        .IN_CLK(IN_CLK), .nRESET(nRESET), .IN_LINE(IN_LINE), .IN_FRAME(IN_FRAME),
        .IN_VIDEO_DATA(IN_VIDEO_DATA), .ENABLE(ENABLE), .AV_CS(AV_CS), .AV_nWR(AV_nWR),
        .AV_nRD(AV_nRD), .AV_ADDR(AV_ADDR), .AV_WRITEDATA(AV_WRITEDATA),
        .AV_WAITREQ(AV_WAITREQ), .BUSY(BUSY), .FRAME_MIN(FRAME_MIN),
        .FRAME_MAX(FRAME_MAX), .DROP_CNT(DROP_CNT), .AV_ERR(AV_ERR)
    );

    always #5 IN_CLK = ~IN_CLK;

    // Slave model
    assign AV_WAITREQ = hold ? 1'b1 : !(AV_CS && s_cnt == 2'd2);
    always @(posedge IN_CLK) begin
        if (!AV_CS || !AV_WAITREQ) s_cnt <= 2'd0;
        else if (s_cnt != 2'd2)    s_cnt <= s_cnt + 2'd1;
    end

    // Completed write capture
    always @(negedge IN_CLK) begin
        if (AV_CS && !AV_nWR && !AV_WAITREQ) begin
            wq_a.push_back(AV_ADDR);
            wq_d.push_back(AV_WRITEDATA);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge IN_CLK);
    endtask

    task automatic set_hold(input logic v);
        @(posedge IN_CLK);
        #1 hold = v;
        @(negedge IN_CLK);
    endtask

    // Drives one frame of n pixels; returns at the negedge right after frame-end edge E
    task automatic frame(input int start, input int step, input int n);
        IN_FRAME = 1'b1; IN_LINE = 1'b0;
        tick(1);
        for (int i = 0; i < n; i++) begin
            IN_LINE = 1'b1;
            IN_VIDEO_DATA = 16'(start + i * step);
            tick(1);
        end
        IN_LINE = 1'b0;
        tick(1);
        IN_FRAME = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string tag);
        tick(2);
        for (int i = 0; i < 500 && BUSY; i++) tick(1);
        chk(tag, 32'(BUSY), 32'd0);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [2:0] a, input logic [31:0] d);
        logic [31:0] oa, od;
        oa = (idx < wq_a.size()) ? 32'(wq_a[idx]) : 32'hxxxxxxxx;
        od = (idx < wq_d.size()) ? wq_d[idx] : 32'hxxxxxxxx;
        chk({tag, "_addr"}, oa, 32'(a));
        chk({tag, "_data"}, od, d);
    endtask

    task automatic clear_q();
        wq_a.delete();
        wq_d.delete();
    endtask

    initial begin
        nRESET = 1'b0; IN_LINE = 1'b0; IN_FRAME = 1'b0; ENABLE = 1'b1;
        IN_VIDEO_DATA = 16'h0;
        tick(3);
        chk("rst_cs", 32'(AV_CS), 32'd0);
        chk("rst_nwr", 32'(AV_nWR), 32'd1);
        chk("rst_nrd", 32'(AV_nRD), 32'd1);
        chk("rst_addr", 32'(AV_ADDR), 32'd0);
        chk("rst_data", AV_WRITEDATA, 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_fmin", 32'(FRAME_MIN), 32'h0000);
        chk("rst_fmax", 32'(FRAME_MAX), 32'hFFFF);
        chk("rst_drop", 32'(DROP_CNT), 32'd0);
        chk("rst_err", 32'(AV_ERR), 32'd0);
        nRESET = 1'b1;
        tick(2);

        // Ramp 100..900 with exact cycle timing
        clear_q();
        frame(100, 1, 801);
        chk("ramp_e0_cs", 32'(AV_CS), 32'd0);
        chk("ramp_e0_busy", 32'(BUSY), 32'd0);
        tick(1);
        chk("ramp_e1_cs", 32'(AV_CS), 32'd1);
        chk("ramp_e1_busy", 32'(BUSY), 32'd1);
        chk("ramp_e1_addr", 32'(AV_ADDR), 32'd1);
        chk("ramp_e1_data", AV_WRITEDATA, 32'h00FF0384);
        tick(2);
        chk("ramp_e3_cs", 32'(AV_CS), 32'd1);
        tick(1);
        chk("ramp_e4_gap", 32'(AV_CS), 32'd0);
        tick(1);
        chk("ramp_e5_addr", 32'(AV_ADDR), 32'd2);
        tick(6);
        chk("ramp_e11_busy", 32'(BUSY), 32'd1);
        chk("ramp_e11_fmin", 32'(FRAME_MIN), 32'd0);
        tick(1);
        chk("ramp_e12_busy", 32'(BUSY), 32'd0);
        chk("ramp_fmin", 32'(FRAME_MIN), 32'd100);
        chk("ramp_fmax", 32'(FRAME_MAX), 32'd900);
        chk("ramp_nwr", 32'(wq_a.size()), 32'd3);
        chk_wr("ramp_w1", 0, 3'd1, 32'h00FF0384);
        chk_wr("ramp_w2", 1, 3'd2, 32'h00000064);
        chk_wr("ramp_w3", 2, 3'd0, 32'h00000001);

        // Flat 5000: span widened to 5016
        clear_q();
        frame(5000, 0, 10);
        wait_idle("flat1_idle");
        chk_wr("flat1_w1", 0, 3'd1, 32'h00FF1398);
        chk_wr("flat1_w2", 1, 3'd2, 32'h00001388);
        chk("flat1_fmin", 32'(FRAME_MIN), 32'd5000);
        chk("flat1_fmax", 32'(FRAME_MAX), 32'd5016);

        // Flat 65530: clamped against the top of range
        clear_q();
        frame(65530, 0, 10);
        wait_idle("flat2_idle");
        chk_wr("flat2_w1", 0, 3'd1, 32'h00FFFFFF);
        chk_wr("flat2_w2", 1, 3'd2, 32'h0000FFEF);
        chk("flat2_fmin", 32'(FRAME_MIN), 32'd65519);
        chk("flat2_fmax", 32'(FRAME_MAX), 32'd65535);

        // ENABLE=0: only the enable register is written
        clear_q();
        ENABLE = 1'b0;
        frame(300, 1, 10);
        wait_idle("dis_idle");
        chk("dis_nwr", 32'(wq_a.size()), 32'd1);
        chk_wr("dis_w1", 0, 3'd0, 32'h00000000);
        ENABLE = 1'b1;
        tick(2);

        // Second frame end while the first sequence is stalled
        clear_q();
        set_hold(1'b1);
        frame(1000, 1, 20);
        frame(2000, 1, 20);
        chk("drop_cnt", 32'(DROP_CNT), 32'd1);
        chk("drop_busy", 32'(BUSY), 32'd1);
        tick(25);
        set_hold(1'b0);
        wait_idle("drop_idle");
        chk("drop_nwr", 32'(wq_a.size()), 32'd3);
        chk_wr("drop_w1", 0, 3'd1, 32'h00FF03FB);
        chk_wr("drop_w2", 1, 3'd2, 32'h000003E8);
        chk_wr("drop_w3", 2, 3'd0, 32'h00000001);
        chk("drop_fmin", 32'(FRAME_MIN), 32'd1000);
        chk("drop_fmax", 32'(FRAME_MAX), 32'd1019);

        // WAITREQ stuck high: abort after 255 stalled samples
        clear_q();
        set_hold(1'b1);
        frame(7000, 1, 20);
        tick(255);
        chk("to_e255_err", 32'(AV_ERR), 32'd0);
        chk("to_e255_cs", 32'(AV_CS), 32'd1);
        tick(1);
        chk("to_err", 32'(AV_ERR), 32'd1);
        chk("to_cs", 32'(AV_CS), 32'd0);
        chk("to_busy", 32'(BUSY), 32'd0);
        chk("to_fmin", 32'(FRAME_MIN), 32'd1000);
        chk("to_fmax", 32'(FRAME_MAX), 32'd1019);
        set_hold(1'b0);
        clear_q();
        frame(1500, 1, 20);
        wait_idle("to_next_idle");
        chk("to_next_nwr", 32'(wq_a.size()), 32'd3);
        chk_wr("to_next_w1", 0, 3'd1, 32'h00FF05EF);
        chk("to_next_fmin", 32'(FRAME_MIN), 32'd1500);
        chk("to_err_sticky", 32'(AV_ERR), 32'd1);

        // Asynchronous reset during WR_MIN
        clear_q();
        frame(2500, 1, 20);
        tick(5);
        chk("rm_addr", 32'(AV_ADDR), 32'd2);
        chk("rm_cs_pre", 32'(AV_CS), 32'd1);
        nRESET = 1'b0;
        #1;
        chk("rm_cs", 32'(AV_CS), 32'd0);
        chk("rm_nwr", 32'(AV_nWR), 32'd1);
        chk("rm_busy", 32'(BUSY), 32'd0);
        chk("rm_drop", 32'(DROP_CNT), 32'd0);
        chk("rm_err", 32'(AV_ERR), 32'd0);
        tick(2);
        nRESET = 1'b1;
        tick(2);
        clear_q();
        frame(3000, 1, 20);
        wait_idle("rm_next_idle");
        chk("rm_next_nwr", 32'(wq_a.size()), 32'd3);
        chk_wr("rm_next_w1", 0, 3'd1, 32'h00FF0BCB);
        chk_wr("rm_next_w2", 1, 3'd2, 32'h00000BB8);
        chk_wr("rm_next_w3", 2, 3'd0, 32'h00000001);
        chk("rm_next_fmin", 32'(FRAME_MIN), 32'd3000);
        chk("rm_next_fmax", 32'(FRAME_MAX), 32'd3019);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
